// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU control codes, opcode classes and branch kinds.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b1011;
    localparam logic [3:0] ALU_PASS = 4'b1111;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    typedef enum logic [1:0] {
        BK_EQ = 2'd0,
        BK_NE = 2'd1,
        BK_LT = 2'd2,
        BK_GE = 2'd3
    } branch_kind_t;

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decode
//  Description : Combinational opcode/funct3/funct7 to ALU control translation.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
    import alu_pkg::*;
(
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic         i_funct7_5,
    output logic [3:0]   o_control,
    output logic         o_is_branch,
    output branch_kind_t o_branch_kind,
    output logic         o_is_shift,
    output logic         o_swap,
    output logic         o_illegal
);

    always_comb begin
        o_control     = ALU_PASS;
        o_is_branch   = 1'b0;
        o_branch_kind = BK_EQ;
        o_is_shift    = 1'b0;
        o_swap        = 1'b0;
        o_illegal     = 1'b0;
        if (i_opcode == OP_R || i_opcode == OP_I) begin
            case (i_funct3)
                3'b000: o_control = (i_opcode == OP_R && i_funct7_5) ? ALU_SUB : ALU_ADD;
                3'b111: o_control = ALU_AND;
                3'b110: o_control = ALU_OR;
                3'b100: o_control = ALU_XOR;
                3'b010: o_control = ALU_SLT;
                3'b001: begin
                    o_control  = ALU_SLL;
                    o_is_shift = 1'b1;
                    o_swap     = 1'b1;
                end
                3'b101: begin
                    o_control  = i_funct7_5 ? ALU_SRA : ALU_SRL;
                    o_is_shift = 1'b1;
                end
                default: o_illegal = 1'b1;
            endcase
        end else if (i_opcode == OP_BR) begin
            o_is_branch = 1'b1;
            case (i_funct3)
                3'b000: begin o_control = ALU_SUB; o_branch_kind = BK_EQ; end
                3'b001: begin o_control = ALU_SUB; o_branch_kind = BK_NE; end
                3'b100: begin o_control = ALU_SLT; o_branch_kind = BK_LT; end
                3'b101: begin o_control = ALU_SLT; o_branch_kind = BK_GE; end
                default: begin
                    o_is_branch = 1'b0;
                    o_illegal   = 1'b1;
                end
            endcase
        end else begin
            o_illegal = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue
//  Description : Two-stage valid/ready issue pipeline wrapped around an external ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [31:0] in_imm,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    input  logic        alu_pos,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_branch,
    output logic        out_taken,
    output logic        out_illegal
);

    logic [3:0]   w_control;
    logic         w_is_branch;
    branch_kind_t w_branch_kind;
    logic         w_is_shift;
    logic         w_swap;
    logic         w_illegal;

    alu_decode u_decode (
        .i_opcode      (in_opcode),
        .i_funct3      (in_funct3),
        .i_funct7_5    (in_funct7[5]),
        .o_control     (w_control),
        .o_is_branch   (w_is_branch),
        .o_branch_kind (w_branch_kind),
        .o_is_shift    (w_is_shift),
        .o_swap        (w_swap),
        .o_illegal     (w_illegal)
    );

    logic w_unused;
    assign w_unused = ^{alu_pos, in_funct7[6], in_funct7[4:0]};

    logic         r_s1_valid;
    logic [31:0]  r_alu_a;
    logic [31:0]  r_alu_b;
    logic [3:0]   r_alu_ctrl;
    logic [4:0]   r_s1_rd;
    logic         r_s1_branch;
    branch_kind_t r_s1_bk;
    logic         r_s1_illegal;

    logic         r_out_valid;
    logic [31:0]  r_out_result;
    logic [4:0]   r_out_rd;
    logic         r_out_branch;
    logic         r_out_taken;
    logic         r_out_illegal;

    logic         w_in_fire;
    logic         w_s2_load;
    logic [31:0]  w_b_src;
    logic [31:0]  w_shamt;
    logic [31:0]  w_a_next;
    logic [31:0]  w_b_next;
    logic         w_taken;

    assign in_ready  = !r_s1_valid || !r_out_valid || out_ready;
    assign w_in_fire = in_valid && in_ready;
    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);

    assign w_b_src = (in_opcode == OP_I) ? in_imm : in_rs2;
    assign w_shamt = {27'b0, w_b_src[4:0]};

    // The ALU computes in_b << in_a, so SLL presents the shift amount on port A.
    always_comb begin
        w_a_next = in_rs1;
        w_b_next = w_b_src;
        if (w_swap) begin
            w_a_next = w_shamt;
            w_b_next = in_rs1;
        end else if (w_is_shift) begin
            w_b_next = w_shamt;
        end
    end

    always_comb begin
        w_taken = 1'b0;
        if (r_s1_branch && !r_s1_illegal) begin
            case (r_s1_bk)
                BK_EQ:   w_taken = alu_zero;
                BK_NE:   w_taken = !alu_zero;
                BK_LT:   w_taken = alu_result[0];
                BK_GE:   w_taken = !alu_result[0];
                default: w_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_alu_a      <= 32'b0;
            r_alu_b      <= 32'b0;
            r_alu_ctrl   <= ALU_PASS;
            r_s1_rd      <= 5'b0;
            r_s1_branch  <= 1'b0;
            r_s1_bk      <= BK_EQ;
            r_s1_illegal <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid   <= 1'b1;
            r_alu_a      <= w_a_next;
            r_alu_b      <= w_b_next;
            r_alu_ctrl   <= w_control;
            r_s1_rd      <= in_rd;
            r_s1_branch  <= w_is_branch;
            r_s1_bk      <= w_branch_kind;
            r_s1_illegal <= w_illegal;
        end else if (w_s2_load) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_out_result  <= 32'b0;
            r_out_rd      <= 5'b0;
            r_out_branch  <= 1'b0;
            r_out_taken   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid   <= 1'b1;
            r_out_result  <= r_s1_illegal ? 32'b0 : alu_result;
            r_out_rd      <= r_s1_rd;
            r_out_branch  <= r_s1_branch;
            r_out_taken   <= w_taken;
            r_out_illegal <= r_s1_illegal;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_control = r_alu_ctrl;
    assign out_valid   = r_out_valid;
    assign out_result  = r_out_result;
    assign out_rd      = r_out_rd;
    assign out_branch  = r_out_branch;
    assign out_taken   = r_out_taken;
    assign out_illegal = r_out_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue
//  Description : Self-checking bench for alu_issue with an ALU model and a reference scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_opcode;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic [31:0] in_rs1, in_rs2, in_imm;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_zero, alu_pos;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_branch, out_taken, out_illegal;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_pos(alu_pos),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd),
        .out_branch(out_branch), .out_taken(out_taken), .out_illegal(out_illegal)
    );

    // Combinational ALU the issue stage sits in front of.
    logic [31:0] alu_diff;
    assign alu_diff = alu_a - alu_b;
    always_comb begin
        alu_result = alu_a;
        case (alu_control)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_diff;
            4'b0111: alu_result = {31'b0, alu_diff[31]};
            4'b1000: alu_result = alu_a ^ alu_b;
            4'b1001: alu_result = alu_a >> alu_b[4:0];
            4'b1010: alu_result = $signed(alu_a) >>> alu_b[4:0];
            4'b1011: alu_result = alu_b << alu_a[4:0];
            default: alu_result = alu_a;
        endcase
    end
    assign alu_zero = (alu_result == 32'b0);
    assign alu_pos  = !alu_result[31] && !alu_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        br;
        logic        tk;
        logic        ill;
        int          t;
    } exp_t;

    exp_t q[$];

    // Instruction semantics straight from the ISA rules, independent of operand routing.
    function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                   input logic [4:0] rd, input logic [31:0] a, input logic [31:0] rs2,
                                   input logic [31:0] imm);
        exp_t e;
        logic [31:0] b, d;
        int sh;
        e.res = 32'b0; e.rd = rd; e.br = 1'b0; e.tk = 1'b0; e.ill = 1'b0; e.t = 0;
        b  = (op == 7'b0010011) ? imm : rs2;
        sh = int'(b[4:0]);
        d  = a - b;
        if (op == 7'b0110011 || op == 7'b0010011) begin
            case (f3)
                3'b000: e.res = (op == 7'b0110011 && f7[5]) ? a - b : a + b;
                3'b111: e.res = a & b;
                3'b110: e.res = a | b;
                3'b100: e.res = a ^ b;
                3'b010: e.res = {31'b0, d[31]};
                3'b001: e.res = a << sh;
                3'b101: e.res = f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
                default: e.ill = 1'b1;
            endcase
        end else if (op == 7'b1100011) begin
            e.br = 1'b1;
            case (f3)
                3'b000: begin e.res = d; e.tk = (a == b); end
                3'b001: begin e.res = d; e.tk = (a != b); end
                3'b100: begin e.res = {31'b0, d[31]}; e.tk = d[31]; end
                3'b101: begin e.res = {31'b0, d[31]}; e.tk = !d[31]; end
                default: begin e.br = 1'b0; e.ill = 1'b1; end
            endcase
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    logic prev_rst = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic exp_valid;
        cyc++;
        if (rst) begin
            q.delete();
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
                chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
                chk("rst_alu_control", {28'b0, alu_control}, 32'hF);
                chk("rst_alu_a", alu_a, 32'd0);
                chk("rst_alu_b", alu_b, 32'd0);
                chk("rst_out_result", out_result, 32'd0);
                chk("rst_out_flags", {27'b0, out_rd, out_branch, out_taken, out_illegal} , 32'd0);
                prev_rst = 1'b0;
            end
            exp_valid = (q.size() > 0) && (q[0].t <= cyc - 2);
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
            chk("in_ready", {31'b0, in_ready}, {31'b0, (q.size() < 2) || out_ready});
            if (out_valid && q.size() > 0) begin
                e = q[0];
                chk("out_result", out_result, e.res);
                chk("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
                chk("out_flags", {29'b0, out_branch, out_taken, out_illegal}, {29'b0, e.br, e.tk, e.ill});
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                e = model(in_opcode, in_funct3, in_funct7, in_rd, in_rs1, in_rs2, in_imm);
                e.t = cyc;
                q.push_back(e);
            end
        end
    end

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] imm);
        in_valid = 1'b1; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = a; in_rs2 = b; in_imm = imm;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                return;
            end
        end
        total++; bad++;
        $display("FAIL send_timeout: in_ready stuck at 0, required 1");
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_opcode = '0; in_funct3 = '0; in_funct7 = '0; in_rd = '0;
        in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle_cycle();

        // SUB
        send(7'b0110011, 3'b000, 7'b0100000, 5'd1, 32'd10, 32'd3, 32'd0);
        chk("sub_ctrl", {28'b0, alu_control}, 32'h6);
        idle_cycle();
        chk("sub_result", out_result, 32'd7);

        // SLL immediate
        send(7'b0010011, 3'b001, 7'b0, 5'd2, 32'h1, 32'h0, 32'd4);
        chk("sll_a", alu_a, 32'd4);
        chk("sll_b", alu_b, 32'd1);
        chk("sll_ctrl", {28'b0, alu_control}, 32'hB);
        idle_cycle();
        chk("sll_result", out_result, 32'h10);

        // BNE not taken, BLT taken
        send(7'b1100011, 3'b001, 7'b0, 5'd3, 32'd5, 32'd5, 32'd0);
        idle_cycle();
        chk("bne_branch", {31'b0, out_branch}, 32'd1);
        chk("bne_taken", {31'b0, out_taken}, 32'd0);
        send(7'b1100011, 3'b100, 7'b0, 5'd4, 32'hFFFF_FFFE, 32'd3, 32'd0);
        idle_cycle();
        chk("blt_taken", {31'b0, out_taken}, 32'd1);

        // Illegal opcode then SLTU, back to back
        send(7'b0110111, 3'b000, 7'b0, 5'd5, 32'h1234, 32'h55, 32'd0);
        chk("ill_ctrl", {28'b0, alu_control}, 32'hF);
        send(7'b0110011, 3'b011, 7'b0, 5'd6, 32'h4321, 32'h66, 32'd0);
        chk("ill1_flags", {29'b0, out_illegal, out_taken, out_branch}, 32'b100);
        chk("ill1_result", out_result, 32'd0);
        chk("sltu_ctrl", {28'b0, alu_control}, 32'hF);
        idle_cycle();
        chk("ill2_illegal", {31'b0, out_illegal}, 32'd1);
        chk("ill2_result", out_result, 32'd0);
        chk("ill2_rd", {27'b0, out_rd}, 32'd6);

        // Eight back-to-back ADDs
        for (int i = 0; i < 8; i++)
            send(7'b0110011, 3'b000, 7'b0, 5'(i), 32'(i * 3), 32'(100 + i), 32'd0);
        repeat (3) idle_cycle();

        // Backpressure
        out_ready = 1'b0;
        send(7'b0010011, 3'b000, 7'b0, 5'd9, 32'd20, 32'd0, 32'd22);
        send(7'b0010011, 3'b100, 7'b0, 5'd10, 32'hF0, 32'd0, 32'hFF);
        in_valid = 1'b1; in_opcode = 7'b0010011; in_funct3 = 3'b110; in_rd = 5'd11;
        in_rs1 = 32'h100; in_imm = 32'h1;
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_result", out_result, 32'd42);
            chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        send(7'b0010011, 3'b110, 7'b0, 5'd11, 32'h100, 32'd0, 32'h1);
        repeat (3) idle_cycle();

        // Reset with both stages full
        out_ready = 1'b0;
        send(7'b0110011, 3'b000, 7'b0, 5'd12, 32'd1, 32'd2, 32'd0);
        send(7'b0110011, 3'b000, 7'b0, 5'd13, 32'd3, 32'd4, 32'd0);
        in_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        chk("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid_ctrl", {28'b0, alu_control}, 32'hF);
        idle_cycle();

        // Randomized traffic with random backpressure
        for (int c = 0; c < 3000; c++) begin
            logic accepted;
            int sel;
            @(negedge clk);
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid || accepted) begin
                if ($urandom_range(0, 4) == 0) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    sel = $urandom_range(0, 9);
                    in_opcode = (sel < 4) ? 7'b0110011 : (sel < 7) ? 7'b0010011 :
                                (sel < 9) ? 7'b1100011 : 7'($urandom);
                    in_funct3 = 3'($urandom);
                    case ($urandom_range(0, 2))
                        0:       in_funct7 = 7'b0000000;
                        1:       in_funct7 = 7'b0100000;
                        default: in_funct7 = 7'($urandom);
                    endcase
                    in_rd  = 5'($urandom);
                    in_rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
                    in_rs2 = ($urandom_range(0, 3) == 0) ? in_rs1 : 32'($urandom);
                    in_imm = ($urandom_range(0, 1) == 0) ? 32'($signed(12'($urandom))) : 32'($urandom);
                end
            end
        end

        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

- Issue stage in front of the 32-bit combinational ALU.
- Accepts decoded instruction fields and operands over a valid/ready handshake, and translates opcode/funct3/funct7 into the ALU's 4-bit control code.
- Drives the ALU operands from a registered stage, captures the result together with `zero`/`pos`, and resolves branch outcome.
- Two-stage pipeline between the register-read stage and writeback/PC-select logic.

## Interface
Parameters:
- None. Data width is fixed at 32, register index at 5.

Ports (clock and reset first):
- `clk` in 1: single clock; all state on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: upstream holds a valid instruction.
- `in_ready` out 1: stage 1 can accept this cycle.
- `in_opcode` in 7: instruction bits [6:0].
- `in_funct3` in 3: instruction bits [14:12].
- `in_funct7` in 7: instruction bits [31:25].
- `in_rd` in 5: destination register index, carried through unchanged.
- `in_rs1` in 32: source operand 1.
- `in_rs2` in 32: source operand 2.
- `in_imm` in 32: sign-extended immediate.
- `alu_a` out 32: ALU `in_a`.
- `alu_b` out 32: ALU `in_b`.
- `alu_control` out 4: ALU control code.
- `alu_result` in 32: ALU output.
- `alu_zero` in 1: ALU zero flag.
- `alu_pos` in 1: ALU pos flag; unused, ignored.
- `out_valid` out 1: stage 2 holds a result.
- `out_ready` in 1: downstream accepts this cycle.
- `out_result` out 32: captured ALU result.
- `out_rd` out 5: destination index.
- `out_branch` out 1: instruction was a branch.
- `out_taken` out 1: branch condition true.
- `out_illegal` out 1: unsupported encoding.

## Operation
Opcode classes:
- R-type = `0110011`
- I-type = `0010011`
- Branch = `1100011`
- Any other opcode → illegal.

ALU op by funct3:
- 000 → ADD `0010`. R-type with funct7[5]=1 → SUB `0110`.
- 111 → AND `0000`.
- 110 → OR `0001`.
- 100 → XOR `1000`.
- 010 → SLT `0111`.
- 001 → SLL `1011`.
- 101 → SRL `1001` when funct7[5]=0; SRA `1010` when funct7[5]=1.
- 011 (SLTU) → illegal.

Branch op by funct3:
- BEQ 000 / BNE 001 → control `0110`. Taken = `alu_zero` for BEQ, `!alu_zero` for BNE.
- BLT 100 / BGE 101 → control `0111`. Taken = `alu_result[0]` for BLT, `!alu_result[0]` for BGE.
- Other funct3 → illegal.

Operand routing:
- Non-shift ops: `alu_a`=rs1; `alu_b`=rs2 for R-type and branches, imm for I-type.
- SRL/SRA: `alu_a`=rs1, `alu_b`={27'b0, shamt}.
- SLL: operands swapped, because the ALU computes `in_b<<in_a`. So `alu_a`={27'b0, shamt}, `alu_b`=rs1.
- shamt = rs2[4:0] for R-type, imm[4:0] for I-type.

Illegal encodings:
- `alu_control`=`1111` (ALU default: passes `in_a`).
- `out_result`=0, `out_taken`=0, `out_branch`=0, `out_illegal`=1.
- Still flows through the pipe; no stall, no drop.

Signed compare:
- SLT/BLT/BGE inherit the ALU's sign-of-difference compare.
- Results are wrong on signed overflow. This is accepted behaviour; the block adds no correction.

## Timing
Pipeline:
- Stage 1 registers decoded control, routed operands, rd, branch kind and illegal flag. It drives `alu_*` directly from those registers.
- Stage 2 registers `alu_result`, `alu_zero`-derived taken, and flags.

Latency and throughput:
- Accepted at edge N; ALU driven during cycle N+1; `out_valid`=1 from edge N+1.
- Throughput is 1 instruction per cycle.

Handshake:
- Transfer occurs when valid && ready.
- `in_ready` = !s1_valid || !out_valid || out_ready. It is combinational from `out_ready`.
- Stage 2 loads when s1_valid && (!out_valid || out_ready).
- Stall (`out_valid` && !`out_ready`): both stages hold and all outputs stay stable. `alu_*` stay stable too, so the ALU result is unchanged when stage 2 later loads.
- Simultaneous accept into stage 1 and advance to stage 2 in the same cycle is required for full throughput.
- `out_*` payload is stable while `out_valid` && !`out_ready`.

Reset (synchronous):
- All valid bits 0. `in_ready`=1 in the cycle after reset.
- `alu_a`=`alu_b`=0, `alu_control`=`1111`.
- All `out_*` = 0.
- Reset mid-operation discards both stages with no output handshake.

## Structure
- Shared package `alu_pkg` holds:
  - 4-bit ALU control localparams: `ALU_AND`, `ALU_OR`, `ALU_ADD`, `ALU_XOR`, `ALU_SRL`, `ALU_SRA`, `ALU_SLL`, `ALU_SUB`, `ALU_SLT`, `ALU_PASS`=`1111`.
  - Opcode constants: `OP_R`, `OP_I`, `OP_BR`.
  - Branch-kind encoding: 2 bits.
- One combinational sub-module, `alu_decode`: opcode/funct3/funct7 → {control, branch_kind, is_shift, swap, illegal}.
- Pipeline registers and handshake stay in `alu_issue`.

## Test plan
- SUB: R-type, funct3 000, funct7 `0100000`, rs1=10, rs2=3 → `alu_control`=`0110`; `out_result`=7 on the cycle after accept.
- SLL: I-type, funct3 001, imm=4, rs1=`0x1` → `alu_a`=4, `alu_b`=1, `alu_control`=`1011`, `out_result`=`0x10`.
- BNE: rs1=5, rs2=5 → `out_branch`=1, `out_taken`=0. BLT with rs1=-2, rs2=3 → `out_taken`=1.
- Illegal: opcode `0110111` then SLTU → `alu_control`=`1111`, `out_illegal`=1, `out_result`=0, `out_taken`=0, in order.
- Throughput and backpressure:
  - 8 back-to-back ADDs with `out_ready`=1 → 8 results on consecutive cycles.
  - Hold `out_ready`=0 for 3 cycles → `in_ready`=0 after the 2nd accept, payload stable, no loss or duplication.
- Reset: assert `rst` with both stages full → next cycle `out_valid`=0, `in_ready`=1, `alu_control`=`1111`.
